// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD widths, limits, scan-select codes and digit step helpers
//
// Package bcd_pkg, imported by bcd_digit and bcd_updown_counter_4d.
//   BCD_W / NUM_DIGITS : digit width and digit count
//   BCD_MAX / BCD_MIN  : legal digit range limits
//   scan_sel_e         : scan-select codes SCAN_D0..SCAN_D3
//   bcd_inc / bcd_dec  : single-digit step including recovery from 10..15

package bcd_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_sel_e;

    // An illegal value (10..15) counting up is treated like 9: it goes to 0 with carry.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_inc = (v >= BCD_MAX) ? BCD_MIN : bcd_t'(v + 4'd1);
    endfunction

    // An illegal value counting down lands on 9 without a borrow.
    function automatic bcd_t bcd_dec(input bcd_t v);
        if (v == BCD_MIN) begin
            bcd_dec = BCD_MAX;
        end else if (v > BCD_MAX) begin
            bcd_dec = BCD_MAX;
        end else begin
            bcd_dec = bcd_t'(v - 4'd1);
        end
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit cell of the up/down counter carry chain
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, value <- 0
//   clr       in   synchronous clear, value <- 0
//   step      in   advance this digit this edge (tick AND carry-in)
//   up_dn     in   1 = increment, 0 = decrement
//   value     out  current digit value
//   carry_out out  this digit would roll over (9 going up / 0 going down)

module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             up_dn,
    output logic [BCD_W-1:0] value,
    output logic             carry_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= BCD_MIN;
        end else if (clr) begin
            value <= BCD_MIN;
        end else if (step) begin
            value <= up_dn ? bcd_inc(value) : bcd_dec(value);
        end
    end

    // Combinational so a carry ripples through every digit in the same edge.
    // Values above 9 also carry when counting up, matching bcd_inc.
    assign carry_out = up_dn ? (value >= BCD_MAX) : (value == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_4d.sv
// rtl/bcd_updown_counter_4d.sv - four-digit BCD up/down counter with prescaler and scan select
//
// Optional feature macro: BCD_SATURATE_EN (saturate at 9999/0000 instead of wrapping).
//
// Parameters:
//   DIV_COUNT  clk cycles per count tick (>= 2)
//   DIV_W      prescaler width, 2^DIV_W >= DIV_COUNT
//   SCAN_W     free-running scan counter width, scan_sel = top two bits
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable; 0 pauses prescaler and digits
//   clr       in   synchronous clear of digits and prescaler
//   up_dn     in   1 = count up, 0 = count down (sampled in the tick cycle)
//   digit0..3 out  BCD digits, least significant first
//   scan_sel  out  digit select for the scan controller
//   tick      out  count-tick strobe
//   wrap      out  one-cycle pulse after rollover (or blocked tick when saturating)

module bcd_updown_counter_4d
    import bcd_pkg::*;
#(
    parameter int DIV_COUNT = 100_000_000,
    parameter int DIV_W     = 27,
    parameter int SCAN_W    = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             up_dn,
    output logic [BCD_W-1:0] digit0,
    output logic [BCD_W-1:0] digit1,
    output logic [BCD_W-1:0] digit2,
    output logic [BCD_W-1:0] digit3,
    output logic [1:0]       scan_sel,
    output logic             tick,
    output logic             wrap
);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_COUNT - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = 1;
    localparam logic [SCAN_W-1:0] SCAN_ONE = 1;

    logic [DIV_W-1:0]      presc;
    logic [SCAN_W-1:0]     scan_cnt;
    logic                  wrap_q;

    bcd_t                  value [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] step;
    logic                  at_limit;
    logic                  limit_hit;

    // ------------------------------------------------------------------
    // Prescaler: a pause holds the count so the period resumes mid-way.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == DIV_LAST) ? '0 : presc + DIV_ONE;
        end
    end

    assign tick = en & (presc == DIV_LAST);

    // ------------------------------------------------------------------
    // Digit chain. All four carries set means the whole counter sits at
    // 9999 going up or 0000 going down, i.e. this tick crosses the limit.
    // ------------------------------------------------------------------
    assign at_limit  = &carry;
    assign limit_hit = tick & at_limit;

`ifdef BCD_SATURATE_EN
    assign step[0] = tick & ~at_limit;
`else
    assign step[0] = tick;
`endif

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_chain
            assign step[gi] = step[gi-1] & carry[gi-1];
        end

        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr),
                .step      (step[gi]),
                .up_dn     (up_dn),
                .value     (value[gi]),
                .carry_out (carry[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Wrap / limit pulse: registered, one cycle after the crossing edge.
    // clr discards a coincident tick, so it also suppresses the pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else if (clr) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= limit_hit;
        end
    end

    // ------------------------------------------------------------------
    // Scan counter: free-running, ignores en and clr.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
        end
    end

    assign scan_sel = scan_cnt[SCAN_W-1:SCAN_W-2];
    assign wrap     = wrap_q;
    assign digit0   = value[0];
    assign digit1   = value[1];
    assign digit2   = value[2];
    assign digit3   = value[3];

endmodule

// File: tb/tb_bcd_updown_counter_4d.sv
// tb/tb_bcd_updown_counter_4d.sv - self-checking bench for bcd_updown_counter_4d

module tb_bcd_updown_counter_4d;

    localparam int DIV_COUNT = 4;
    localparam int DIV_W     = 3;
    localparam int SCAN_W    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       up_dn = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] scan_sel;
    logic       tick;
    logic       wrap;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: counter value as a plain integer 0..9999.
    int m_cnt  = 0;
    int m_p    = 0;
    int m_sc   = 0;
    bit m_wrap = 1'b0;

    bcd_updown_counter_4d #(
        .DIV_COUNT (DIV_COUNT),
        .DIV_W     (DIV_W),
        .SCAN_W    (SCAN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .up_dn    (up_dn),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .scan_sel (scan_sel),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int c);
        to_bcd = {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [15:0] dig();
        dig = {digit3, digit2, digit1, digit0};
    endfunction

    function automatic bit exp_tick();
        exp_tick = en && (m_p == DIV_COUNT - 1);
    endfunction

    function automatic logic [1:0] exp_scan();
        exp_scan = 2'(m_sc >> (SCAN_W - 2));
    endfunction

    // One clock edge applied to the model, then settle 1 time unit past the edge.
    task automatic run_cycle();
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_p = 0; m_sc = 0; m_wrap = 1'b0;
        end else begin
            m_sc   = (m_sc + 1) % (1 << SCAN_W);
            m_wrap = 1'b0;
            if (clr) begin
                m_cnt = 0; m_p = 0;
            end else if (en) begin
                if (m_p == DIV_COUNT - 1) begin
                    m_p = 0;
                    if (up_dn) begin
                        if (m_cnt == 9999) begin
                            m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
                            m_cnt = 0;
`endif
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end else begin
                        if (m_cnt == 0) begin
                            m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
                            m_cnt = 9999;
`endif
                        end else begin
                            m_cnt = m_cnt - 1;
                        end
                    end
                end else begin
                    m_p = m_p + 1;
                end
            end
        end
        #1;
    endtask

    // Advance to the next tick cycle and through its edge (bounded).
    task automatic run_through_tick();
        for (int i = 0; i < 2 * DIV_COUNT && !exp_tick(); i++) run_cycle();
        run_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; up_dn = 1'b1;
        run_cycle();
        run_cycle();
        n_total++;
        if ({dig(), scan_sel, wrap, tick} !== 24'h0) $display("FAIL reset_state: got %h expected 000000", {dig(), scan_sel, wrap, tick});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            n_total++;
            if ({dig(), wrap, tick, scan_sel} !== {to_bcd(m_cnt), m_wrap, exp_tick(), exp_scan()})
                $display("FAIL up_count cyc%0d: got %h/%b/%b/%0d expected %h/%b/%b/%0d", i, dig(), wrap, tick, scan_sel,
                         to_bcd(m_cnt), m_wrap, exp_tick(), exp_scan());
            else n_pass++;
        end
        n_total++;
        if (dig() !== 16'h0010) $display("FAIL up_count_40: got %h expected 0010", dig());
        else n_pass++;
    endtask

    task automatic test_carry_and_wrap();
        logic [15:0] exp_lim;
        up_dn = 1'b1; en = 1'b1;
        for (int i = 0; i < 8000 && m_cnt != 999; i++) run_cycle();
        n_total++;
        if (dig() !== 16'h0999) $display("FAIL reach_0999: got %h expected 0999", dig());
        else n_pass++;
        run_through_tick();
        n_total++;
        if ({dig(), wrap} !== {16'h1000, 1'b0}) $display("FAIL ripple_1000: got %h wrap %b expected 1000 wrap 0", dig(), wrap);
        else n_pass++;
        for (int i = 0; i < 60000 && m_cnt != 9999; i++) run_cycle();
        n_total++;
        if (dig() !== 16'h9999) $display("FAIL reach_9999: got %h expected 9999", dig());
        else n_pass++;
        run_through_tick();
`ifdef BCD_SATURATE_EN
        exp_lim = 16'h9999;
`else
        exp_lim = 16'h0000;
`endif
        n_total++;
        if ({dig(), wrap} !== {exp_lim, 1'b1}) $display("FAIL up_wrap: got %h wrap %b expected %h wrap 1", dig(), wrap, exp_lim);
        else n_pass++;
        run_cycle();
        n_total++;
        if (wrap !== 1'b0) $display("FAIL up_wrap_one_cycle: got wrap %b expected 0", wrap);
        else n_pass++;
    endtask

    task automatic test_down_wrap();
        logic [15:0] e1, e2;
        logic        w2;
        clr = 1'b1;
        run_cycle();
        clr = 1'b0;
        n_total++;
        if ({dig(), wrap, tick} !== 18'h0) $display("FAIL clr_zero: got %h wrap %b tick %b expected 0000 0 0", dig(), wrap, tick);
        else n_pass++;
        up_dn = 1'b0;
`ifdef BCD_SATURATE_EN
        e1 = 16'h0000; e2 = 16'h0000; w2 = 1'b1;
`else
        e1 = 16'h9999; e2 = 16'h9998; w2 = 1'b0;
`endif
        run_through_tick();
        n_total++;
        if ({dig(), wrap} !== {e1, 1'b1}) $display("FAIL down_wrap: got %h wrap %b expected %h wrap 1", dig(), wrap, e1);
        else n_pass++;
        run_through_tick();
        n_total++;
        if ({dig(), wrap} !== {e2, w2}) $display("FAIL down_next: got %h wrap %b expected %h wrap %b", dig(), wrap, e2, w2);
        else n_pass++;
        up_dn = 1'b1;
    endtask

    task automatic test_pause();
        logic [15:0] held;
        en = 1'b1;
        for (int i = 0; i < 2 * DIV_COUNT && m_p != 2; i++) run_cycle();
        held = dig();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            up_dn = 1'($urandom_range(0, 1));
            #1;
            n_total++;
            if ({tick, dig()} !== {1'b0, held}) $display("FAIL pause cyc%0d: got tick %b %h expected tick 0 %h", i, tick, dig(), held);
            else n_pass++;
            run_cycle();
        end
        up_dn = 1'b1;
        en = 1'b1;
        #1;
        n_total++;
        if (tick !== 1'b0) $display("FAIL resume_early: got tick %b expected 0", tick);
        else n_pass++;
        run_cycle();
        n_total++;
        if (tick !== 1'b1) $display("FAIL resume_tick: got tick %b expected 1", tick);
        else n_pass++;
    endtask

    task automatic test_clear_and_reset();
        clr = 1'b1;
        run_cycle();
        clr = 1'b0; up_dn = 1'b1; en = 1'b1;
        for (int i = 0; i < 400 && m_cnt != 42; i++) run_cycle();
        for (int i = 0; i < 2 * DIV_COUNT && !exp_tick(); i++) run_cycle();
        n_total++;
        if ({dig(), tick} !== {16'h0042, 1'b1}) $display("FAIL pre_clr: got %h tick %b expected 0042 tick 1", dig(), tick);
        else n_pass++;
        clr = 1'b1;
        run_cycle();
        clr = 1'b0;
        n_total++;
        if ({dig(), wrap, tick} !== 18'h0) $display("FAIL clr_in_tick: got %h wrap %b tick %b expected 0000 0 0", dig(), wrap, tick);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            run_cycle();
            n_total++;
            if (scan_sel !== exp_scan()) $display("FAIL scan_step cyc%0d: got %0d expected %0d", i, scan_sel, exp_scan());
            else n_pass++;
        end
        rst = 1'b1;
        run_cycle();
        n_total++;
        if ({dig(), scan_sel, wrap, tick} !== 24'h0) $display("FAIL mid_reset: got %h expected 000000", {dig(), scan_sel, wrap, tick});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            run_cycle();
            n_total++;
            if ({dig(), wrap, scan_sel} !== {to_bcd(m_cnt), m_wrap, exp_scan()})
                $display("FAIL random cyc%0d: got %h/%b/%0d expected %h/%b/%0d", i, dig(), wrap, scan_sel,
                         to_bcd(m_cnt), m_wrap, exp_scan());
            else n_pass++;
            n_total++;
            if (tick !== exp_tick()) $display("FAIL random_tick cyc%0d: got %b expected %b", i, tick, exp_tick());
            else n_pass++;
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_carry_and_wrap();
        test_down_wrap();
        test_pause();
        test_clear_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_4d.md
Name: bcd_updown_counter_4d

Overview:
- Four-digit BCD up/down counter with integrated prescaler and display-scan generator.
- Sits directly upstream of the 7-segment scan controller.
- Drives the four binary digit inputs (digit0..digit3, least significant first) and the scan-select used to multiplex them.
- Used as the timer/counter core for the lab display: pause, clear and direction controls come from debounced board switches.

Parameters:
- DIV_COUNT, 100_000_000: clk cycles per count tick (1 Hz at 100 MHz); must be >= 2.
- DIV_W, 27: width of prescaler register; must satisfy 2^DIV_W >= DIV_COUNT.
- SCAN_W, 18: width of free-running scan counter; scan_sel = top 2 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  count enable; 0 pauses prescaler and digits
- clr  in  1  synchronous clear of digits and prescaler
- up_dn  in  1  1 = count up, 0 = count down
- digit0  out  4  BCD ones digit
- digit1  out  4  BCD tens digit
- digit2  out  4  BCD hundreds digit
- digit3  out  4  BCD thousands digit
- scan_sel  out  2  digit-select for scan controller
- tick  out  1  count-tick strobe
- wrap  out  1  one-cycle pulse after 9999->0000 or 0000->9999

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - digits = 0000, prescaler = 0, scan counter = 0.
  - scan_sel = 2'b00, wrap = 0, tick = 0.
- Priority per edge: rst > clr > count.
- Prescaler:
  - When en=1, counts 0..DIV_COUNT-1, then wraps to 0.
  - When en=0, holds its value; a pause resumes mid-period.
- tick:
  - tick = en AND (prescaler == DIV_COUNT-1); combinational decode of registered state.
  - Exactly one cycle per DIV_COUNT enabled cycles.
- Digit update:
  - Occurs on the rising edge that ends a tick cycle.
  - Digits are visible the next cycle (latency 1 from tick).
- Up count:
  - digit0 +1; 9->0 with carry into the next digit; carry ripples through all four digits in the same edge.
  - 9999->0000 sets wrap.
- Down count:
  - digit0 -1; 0->9 with borrow into the next digit, rippling in the same edge.
  - 0000->9999 sets wrap.
- up_dn is sampled only in the tick cycle; changing it between ticks has no effect.
- wrap: registered; high for exactly the one cycle following the wrapping edge; otherwise 0.
- clr:
  - Digits <- 0000 and prescaler <- 0; any tick in the same cycle is discarded; wrap <- 0.
  - scan counter is unaffected.
- Scan counter:
  - Free-running +1 every cycle, regardless of en/clr.
  - Wraps modulo 2^SCAN_W.
  - scan_sel = scan_cnt[SCAN_W-1:SCAN_W-2].
- Digits never hold values 10..15; if ever forced there, the next up count sets that digit to 0 with carry, and the next down count sets it to 9.
- Reset mid-count: all state returns to reset values on that edge; no wrap pulse is generated.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined:
  - Counter saturates: up at 9999 holds 9999; down at 0000 holds 0000.
  - wrap pulses in the cycle after a tick that was blocked by saturation (signals "limit hit").
- Undefined: modulo-10000 wrap-around as above.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4, BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - NUM_DIGITS = 4.
  - Scan-select encoding constants SCAN_D0..SCAN_D3 = 2'd0..2'd3.
- Sub-module bcd_digit, instantiated 4x:
  - Inputs: clk, rst, clr, step (tick AND carry-in), up_dn.
  - Outputs: 4-bit value, carry_out (value==9 & up, or value==0 & down).
  - Carry chain is combinational between instances.

Test Plan (DIV_COUNT=4, DIV_W=3, SCAN_W=4 overrides):
- Reset then en=1, up_dn=1 for 40 cycles -> tick every 4th cycle; digits reach 0010 after 10 ticks; digit0 sequence 0..9,0.
- Force count to 0999 via ticks, then one more up tick -> 1000 in the single edge; wrap stays 0.
- Count up to 9999, one more tick -> 0000 and wrap=1 for exactly one cycle (BCD_SATURATE_EN: stays 9999, wrap=1 one cycle).
- From 0000, up_dn=0, one tick -> 9999 and wrap=1; next tick -> 9998, wrap=0.
- en=0 for 7 cycles at prescaler=2 -> no tick, digits frozen; en=1 -> tick after exactly 1 more cycle.
- clr asserted in a tick cycle at 0042 -> digits 0000 next cycle, no count; scan_sel keeps stepping 0,1,2,3 every 4 cycles throughout; rst mid-run -> all outputs 0 next cycle.
